// File: rtl/vga_write_arbiter.sv
// Purpose: round-robin, burst-based arbiter sharing one VGA write port between three pixel producers.
// Latency: grant 1 cycle after req; each pixel reaches the VGA port 1 cycle after its plot_in.
// Backpressure: none; non-owners are held off by their missing grant, and a stalled owner is revoked after TIMEOUT cycles.
module vga_write_arbiter #(
   parameter int N_REQ    = 3,
   parameter int COLOUR_W = 3,
   parameter int TIMEOUT  = 1024
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ-1:0]          plot_in,
   input  logic [N_REQ-1:0]          last_in,
   input  logic [9*N_REQ-1:0]        x_in,
   input  logic [8*N_REQ-1:0]        y_in,
   input  logic [COLOUR_W*N_REQ-1:0] colour_in,
   output logic [N_REQ-1:0]          grant,
   output logic [1:0]                owner,
   output logic                      busy,
   output logic [8:0]                vga_x,
   output logic [7:0]                vga_y,
   output logic [COLOUR_W-1:0]       vga_colour,
   output logic                      vga_plot,
   output logic                      timeout_err
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic {ST_IDLE, ST_OWN} state_t;

   state_t              state_q, state_d;
   logic [1:0]          rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]    stall_q, stall_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [1:0]          owner_q, owner_d;
   logic                busy_q, busy_d;
   logic [8:0]          vga_x_q, vga_x_d;
   logic [7:0]          vga_y_q, vga_y_d;
   logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
   logic                vga_plot_q, vga_plot_d;
   logic                timeout_err_q, timeout_err_d;

   // Owner's view of the request bundle
   logic                own_req, own_plot, own_last;
   logic [8:0]          own_x;
   logic [7:0]          own_y;
   logic [COLOUR_W-1:0] own_colour;

   // Round-robin pick
   logic [1:0]          cand0, cand1, cand2, sel;
   logic                sel_vld;
   logic                rel;

   function automatic logic [1:0] next_idx(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Mux the current owner's request, strobes and pixel fields
   always_comb begin
      own_req    = 1'b0;
      own_plot   = 1'b0;
      own_last   = 1'b0;
      own_x      = '0;
      own_y      = '0;
      own_colour = '0;
      case (owner_q)
         2'd0: begin
            own_req = req[0]; own_plot = plot_in[0]; own_last = last_in[0];
            own_x = x_in[8:0]; own_y = y_in[7:0]; own_colour = colour_in[COLOUR_W-1:0];
         end
         2'd1: begin
            own_req = req[1]; own_plot = plot_in[1]; own_last = last_in[1];
            own_x = x_in[17:9]; own_y = y_in[15:8]; own_colour = colour_in[2*COLOUR_W-1:COLOUR_W];
         end
         2'd2: begin
            own_req = req[2]; own_plot = plot_in[2]; own_last = last_in[2];
            own_x = x_in[26:18]; own_y = y_in[23:16]; own_colour = colour_in[3*COLOUR_W-1:2*COLOUR_W];
         end
         default: ;
      endcase
   end

   // First pending requester at or after rr_ptr, wrapping 2 -> 0
   always_comb begin
      cand0   = rr_ptr_q;
      cand1   = next_idx(cand0);
      cand2   = next_idx(cand1);
      sel     = 2'd0;
      sel_vld = 1'b0;
      if (req[cand0]) begin
         sel = cand0; sel_vld = 1'b1;
      end else if (req[cand1]) begin
         sel = cand1; sel_vld = 1'b1;
      end else if (req[cand2]) begin
         sel = cand2; sel_vld = 1'b1;
      end
   end

   // Next-state: grant in IDLE, forward pixels and check release in OWN
   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      stall_d       = stall_q;
      grant_d       = grant_q;
      owner_d       = owner_q;
      busy_d        = busy_q;
      vga_x_d       = vga_x_q;
      vga_y_d       = vga_y_q;
      vga_colour_d  = vga_colour_q;
      vga_plot_d    = 1'b0;
      timeout_err_d = 1'b0;
      rel           = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sel_vld) begin
               state_d       = ST_OWN;
               grant_d       = '0;
               grant_d[sel]  = 1'b1;
               owner_d       = sel;
               busy_d        = 1'b1;
               stall_d       = '0;
            end
         end
         ST_OWN: begin
            vga_x_d      = own_x;
            vga_y_d      = own_y;
            vga_colour_d = own_colour;
            // A last pixel is written even if req drops with it; otherwise a dropped req suppresses the write
            vga_plot_d   = own_plot & (own_last | own_req);
            if (own_plot)
               stall_d = '0;
            else if (stall_q != STALL_MAX)
               stall_d = stall_q + CNT_W'(1);
            rel = (own_plot & own_last) | ~own_req | (~own_plot & (stall_q == STALL_MAX));
            // Only a genuine timeout flags an error; an earlier-priority release masks it
            timeout_err_d = own_req & ~own_plot & (stall_q == STALL_MAX);
            if (rel) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               busy_d   = 1'b0;
               rr_ptr_d = next_idx(owner_q);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         rr_ptr_q      <= '0;
         stall_q       <= '0;
         grant_q       <= '0;
         owner_q       <= '0;
         busy_q        <= 1'b0;
         vga_x_q       <= '0;
         vga_y_q       <= '0;
         vga_colour_q  <= '0;
         vga_plot_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         stall_q       <= stall_d;
         grant_q       <= grant_d;
         owner_q       <= owner_d;
         busy_q        <= busy_d;
         vga_x_q       <= vga_x_d;
         vga_y_q       <= vga_y_d;
         vga_colour_q  <= vga_colour_d;
         vga_plot_q    <= vga_plot_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign grant       = grant_q;
   assign owner       = owner_q;
   assign busy        = busy_q;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_colour  = vga_colour_q;
   assign vga_plot    = vga_plot_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Purpose: directed bench for vga_write_arbiter (bursts, round-robin, isolation, timeout, req drop, reset).
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1 time unit after the next.
// Backpressure: none; every wait is a fixed number of clock ticks.
module tb_vga_write_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  req, plot_in, last_in;
   logic [26:0] x_in;
   logic [23:0] y_in;
   logic [8:0]  colour_in;
   logic [2:0]  grant;
   logic [1:0]  owner;
   logic        busy;
   logic [8:0]  vga_x;
   logic [7:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        timeout_err;

   int cmps = 0;
   int errs = 0;

   vga_write_arbiter #(.N_REQ(3), .COLOUR_W(3), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset), .req(req), .plot_in(plot_in), .last_in(last_in),
      .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
      .grant(grant), .owner(owner), .busy(busy),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .timeout_err(timeout_err)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pix(input int i, input logic p, input logic l, input int x, input int y, input int c);
      plot_in[i]          = p;
      last_in[i]          = l;
      x_in[9*i +: 9]      = 9'(x);
      y_in[8*i +: 8]      = 8'(y);
      colour_in[3*i +: 3] = 3'(c);
   endtask

   task automatic idle_inputs();
      req = '0; plot_in = '0; last_in = '0; x_in = '0; y_in = '0; colour_in = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      cmps++; if (grant !== 3'b000) begin errs++; $display("FAIL rst_grant act=%b exp=000", grant); end
      cmps++; if (busy !== 1'b0 || owner !== 2'd0) begin errs++; $display("FAIL rst_busy_owner act=%b/%0d exp=0/0", busy, owner); end
      cmps++; if ({vga_x, vga_y, vga_colour} !== 20'd0) begin errs++; $display("FAIL rst_pixel act=%0d,%0d,%0d exp=0,0,0", vga_x, vga_y, vga_colour); end
      cmps++; if (vga_plot !== 1'b0 || timeout_err !== 1'b0) begin errs++; $display("FAIL rst_plot_terr act=%b/%b exp=0/0", vga_plot, timeout_err); end
   endtask

   task automatic test_single_burst();
      do_reset();
      req = 3'b001;
      tick();
      cmps++; if (grant !== 3'b001 || busy !== 1'b1 || vga_plot !== 1'b0) begin errs++; $display("FAIL sb_grant act=%b/%b/%b exp=001/1/0", grant, busy, vga_plot); end
      for (int k = 0; k < 3; k++) begin
         pix(0, 1'b1, (k == 2), 10 + k, 20, 5);
         tick();
         cmps++; if (vga_plot !== 1'b1 || vga_x !== 9'(10 + k) || vga_y !== 8'd20 || vga_colour !== 3'd5) begin
            errs++; $display("FAIL sb_pixel%0d act=%b,%0d,%0d,%0d exp=1,%0d,20,5", k, vga_plot, vga_x, vga_y, vga_colour, 10 + k);
         end
      end
      cmps++; if (grant !== 3'b000 || busy !== 1'b0) begin errs++; $display("FAIL sb_release act=%b/%b exp=000/0", grant, busy); end
      // rr_ptr is now 1: with requesters 0 and 2 pending, 2 must win
      pix(0, 1'b0, 1'b0, 0, 0, 0);
      req = 3'b101;
      tick();
      cmps++; if (grant !== 3'b100 || vga_plot !== 1'b0) begin errs++; $display("FAIL sb_rrptr act=%b/%b exp=100/0", grant, vga_plot); end
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g;
      do_reset();
      req = 3'b111;
      tick();
      cmps++; if (grant !== 3'b001) begin errs++; $display("FAIL rr_first act=%b exp=001", grant); end
      for (int i = 0; i < 3; i++) begin
         exp_g = 3'b001 << i;
         pix(i, 1'b1, 1'b0, 40 + i, 50, i);
         tick();
         cmps++; if (grant !== exp_g || vga_plot !== 1'b1 || vga_x !== 9'(40 + i)) begin errs++; $display("FAIL rr_px%0d act=%b/%b/%0d exp=%b/1/%0d", i, grant, vga_plot, vga_x, exp_g, 40 + i); end
         pix(i, 1'b1, 1'b1, 41 + i, 50, i);
         tick();
         cmps++; if (grant !== 3'b000 || vga_plot !== 1'b1) begin errs++; $display("FAIL rr_rel%0d act=%b/%b exp=000/1", i, grant, vga_plot); end
         pix(i, 1'b0, 1'b0, 0, 0, 0);
         tick();
         exp_g = (i == 2) ? 3'b001 : (3'b001 << (i + 1));
         cmps++; if (grant !== exp_g || vga_plot !== 1'b0 || owner !== 2'((i + 1) % 3)) begin
            errs++; $display("FAIL rr_next%0d act=%b/%b/%0d exp=%b/0/%0d", i, grant, vga_plot, owner, exp_g, (i + 1) % 3);
         end
      end
   endtask

   task automatic test_isolation();
      do_reset();
      req = 3'b010;
      tick();
      cmps++; if (grant !== 3'b010) begin errs++; $display("FAIL iso_grant act=%b exp=010", grant); end
      for (int k = 0; k < 4; k++) begin
         pix(1, 1'b1, (k == 3), 100 + k, 7, 3);
         pix(2, 1'b1, 1'b1, 300, 9, 6);
         tick();
         cmps++; if (vga_x !== 9'(100 + k) || vga_plot !== 1'b1 || vga_colour !== 3'd3) begin
            errs++; $display("FAIL iso_px%0d act=%0d/%b/%0d exp=%0d/1/3", k, vga_x, vga_plot, vga_colour, 100 + k);
         end
      end
      pix(1, 1'b0, 1'b0, 0, 0, 0);
      req = 3'b000;
      tick();
      cmps++; if (vga_x === 9'd300 || vga_plot !== 1'b0 || grant !== 3'b000) begin errs++; $display("FAIL iso_after act=%0d/%b/%b exp=!300/0/000", vga_x, vga_plot, grant); end
   endtask

   task automatic test_timeout();
      do_reset();
      req = 3'b100;
      tick();
      cmps++; if (grant !== 3'b100) begin errs++; $display("FAIL to_grant act=%b exp=100", grant); end
      req = 3'b101;
      for (int k = 0; k < 7; k++) begin
         tick();
         cmps++; if (grant !== 3'b100 || timeout_err !== 1'b0) begin errs++; $display("FAIL to_hold%0d act=%b/%b exp=100/0", k, grant, timeout_err); end
      end
      tick();
      cmps++; if (grant !== 3'b000 || timeout_err !== 1'b1 || vga_plot !== 1'b0) begin errs++; $display("FAIL to_revoke act=%b/%b/%b exp=000/1/0", grant, timeout_err, vga_plot); end
      tick();
      cmps++; if (grant !== 3'b001 || timeout_err !== 1'b0) begin errs++; $display("FAIL to_next act=%b/%b exp=001/0", grant, timeout_err); end
   endtask

   task automatic test_req_drop();
      do_reset();
      req = 3'b001;
      tick();
      pix(0, 1'b1, 1'b0, 5, 6, 1);
      tick();
      cmps++; if (vga_plot !== 1'b1 || vga_x !== 9'd5) begin errs++; $display("FAIL rd_pixel act=%b/%0d exp=1/5", vga_plot, vga_x); end
      req = 3'b000;
      pix(0, 1'b1, 1'b0, 6, 6, 1);
      tick();
      cmps++; if (vga_plot !== 1'b0 || grant !== 3'b000 || busy !== 1'b0 || timeout_err !== 1'b0) begin
         errs++; $display("FAIL rd_release act=%b/%b/%b/%b exp=0/000/0/0", vga_plot, grant, busy, timeout_err);
      end
   endtask

   task automatic test_back_to_back_last_drop();
      // last+plot with req dropping in the same cycle: pixel written, one release
      do_reset();
      req = 3'b011;
      tick();
      req = 3'b010;
      pix(0, 1'b1, 1'b1, 77, 8, 2);
      tick();
      cmps++; if (vga_plot !== 1'b1 || vga_x !== 9'd77 || grant !== 3'b000) begin errs++; $display("FAIL bb_last act=%b/%0d/%b exp=1/77/000", vga_plot, vga_x, grant); end
      pix(0, 1'b0, 1'b0, 0, 0, 0);
      tick();
      cmps++; if (grant !== 3'b010 || vga_plot !== 1'b0) begin errs++; $display("FAIL bb_next act=%b/%b exp=010/0", grant, vga_plot); end
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      // leave rr_ptr at 2 before the interrupted burst
      req = 3'b010;
      tick();
      req = 3'b000;
      tick();
      req = 3'b001;
      tick();
      cmps++; if (grant !== 3'b001) begin errs++; $display("FAIL rm_grant act=%b exp=001", grant); end
      pix(0, 1'b1, 1'b0, 9, 9, 7);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      cmps++; if (grant !== 3'b000 || busy !== 1'b0 || vga_plot !== 1'b0 || {vga_x, vga_y, vga_colour} !== 20'd0 || owner !== 2'd0) begin
         errs++; $display("FAIL rm_outputs act=%b/%b/%b/%0d/%0d exp=000/0/0/0/0", grant, busy, vga_plot, vga_x, owner);
      end
      pix(0, 1'b0, 1'b0, 0, 0, 0);
      req = 3'b110;
      tick();
      cmps++; if (grant !== 3'b010) begin errs++; $display("FAIL rm_rrptr act=%b exp=010", grant); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single_burst();
      test_round_robin();
      test_isolation();
      test_timeout();
      test_req_drop();
      test_back_to_back_last_drop();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single VGA adapter write port (x, y, colour, plot) between three pixel producers.
  - Requester 0: map drawer.
  - Requester 1: pillar animator.
  - Requester 2: sprite drawer/eraser.
- Grants are burst-based and round-robin: a requester holds the port until it flags its last pixel, drops its request, or stalls past a timeout.
- Sits between the drawing engines and the VGA adapter. Once granted, a map redraw or animation frame completes without pixels interleaving from the sprite engine.

Parameters:
- N_REQ, 3, number of requesters (fixed at 3; RR pointer is 2 bits).
- COLOUR_W, 3, colour bits per pixel.
- TIMEOUT, 1024, owner cycles without a plot before the grant is revoked (must be ≥2).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req  in  3  per-requester request, level
- plot_in  in  3  per-requester pixel-valid strobe
- last_in  in  3  per-requester last-pixel-of-burst flag, qualified by plot_in
- x_in  in  27  packed 9-bit x, requester i at [9i+8:9i]
- y_in  in  24  packed 8-bit y, requester i at [8i+7:8i]
- colour_in  in  3*COLOUR_W  packed colour
- grant  out  3  one-hot grant, registered
- owner  out  2  index of current owner (valid when busy)
- busy  out  1  high while a grant is held
- vga_x  out  9  registered pixel x
- vga_y  out  8  registered pixel y
- vga_colour  out  COLOUR_W  registered colour
- vga_plot  out  1  registered write enable to VGA adapter
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (synchronous, active-high):
  - grant=0, owner=0, busy=0, vga_x/y/colour=0, vga_plot=0, timeout_err=0.
  - rr_ptr=0, stall counter=0, state=IDLE.
  - Reset mid-burst: all outputs are 0 after the reset edge; no pixel is emitted on that edge.
- States: IDLE, OWN.
- IDLE:
  - vga_plot=0.
  - If any req bit is set, select the first set bit searching upward from rr_ptr with wrap (2→0).
  - Next edge: grant=onehot(sel), owner=sel, busy=1, stall counter=0, state=OWN.
  - Grant latency from req: 1 cycle.
- OWN:
  - Each edge: vga_x/y/colour ← owner's slice; vga_plot ← plot_in[owner].
  - Pixel latency is exactly 1 cycle, so one pixel per cycle is sustainable.
  - plot_in/last_in from non-owners are ignored and produce no write.
- Release conditions in OWN, evaluated each cycle in this priority:
  1. plot_in[owner] & last_in[owner]: the last pixel is still written (vga_plot=1 next edge) and the grant is released on the same edge.
  2. req[owner]=0: release; no pixel is written even if plot_in is high that cycle.
  3. Stall counter == TIMEOUT-1 and plot_in[owner]=0: release and pulse timeout_err for one cycle.
- On any release:
  - grant=0, busy=0, state=IDLE, rr_ptr=(owner+1) mod 3.
  - Minimum 1 idle cycle between bursts, so grants never overlap and never switch directly between owners.
- Stall counter:
  - Clears on any owner plot; increments otherwise while in OWN.
  - Width is clog2(TIMEOUT); it saturates and never wraps (release occurs first).
- last_in without plot_in has no effect.
- Simultaneous last+plot with req dropping on the same cycle: rule 1 applies, so the pixel is written and exactly one release occurs.
- A requester that keeps req high after release is eligible again; round-robin guarantees every other pending requester is served first.
- grant, owner and busy change only on release or new-grant edges.

Test Plan:
- Single burst: req[0]=1 from cycle 0; plots at (10,20,c=5),(11,20,5),(12,20,5), last on the third → grant=001 at cycle 1; vga_plot high for three consecutive cycles, each 1 cycle after its plot_in; grant=000 one cycle after the last pixel; rr_ptr=1.
- Round-robin: req=111 held, each owner sends a 2-pixel burst → grant sequence 001, 000, 010, 000, 100, 000, 001; no vga_plot during the idle gaps.
- Isolation: requester 1 owns; requester 2 pulses plot_in with x=300 → vga_x never equals 300; only requester 1 pixels appear on the port.
- Timeout: TIMEOUT=8; requester 2 granted, never plots → after 8 owner cycles grant=000, timeout_err is a single-cycle pulse, requester 0 is granted next if pending.
- Req drop: the owner deasserts req mid-burst with plot_in=1 → no write that cycle, release next edge, timeout_err=0.
- Reset mid-burst: reset asserted for 1 cycle during a requester 0 burst → all outputs 0 after the edge, rr_ptr=0; after reset, req=110 grants requester 1 first.
